// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back, write-allocate data cache (optional stats via DCACHE_STATS_EN)
module data_cache #(
    parameter int LINE_COUNT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_input_valid,
    input  logic [31:0] addr,
    input  logic        mem_rw,
    input  logic [31:0] din,
    output logic        is_ready,
    output logic        is_output_valid,
    output logic [31:0] dout,
    output logic        is_hit,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IW = $clog2(LINE_COUNT);
    localparam int TW = 32 - 4 - IW;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    state_t          state;
    logic [31:2]     req_addr;
    logic [31:0]     req_din;
    logic            req_rw;
    logic            miss_flag;
    logic [1:0]      word_cnt;

    logic [LINE_COUNT-1:0] valid_bits;
    logic [LINE_COUNT-1:0] dirty_bits;
    logic [TW-1:0]         tag_array  [LINE_COUNT];
    logic [31:0]           data_array [LINE_COUNT][4];

    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_index;
    logic [1:0]    req_word;
    logic          lookup_hit;

    // Byte-lane bits never reach the cache; the word is the smallest unit.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    assign req_tag    = req_addr[31:4+IW];
    assign req_index  = req_addr[3+IW:4];
    assign req_word   = req_addr[3:2];
    assign lookup_hit = valid_bits[req_index] && (tag_array[req_index] == req_tag);

    // Controller FSM: request latch, miss tracking, line state bits and burst counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_addr   <= '0;
            req_din    <= '0;
            req_rw     <= 1'b0;
            miss_flag  <= 1'b0;
            word_cnt   <= 2'd0;
            valid_bits <= '0;
            dirty_bits <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_input_valid) begin
                        req_addr  <= addr[31:2];
                        req_din   <= din;
                        req_rw    <= mem_rw;
                        miss_flag <= 1'b0;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (lookup_hit) begin
                        if (req_rw) begin
                            dirty_bits[req_index] <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        miss_flag <= 1'b1;
                        // A dirty bit is only ever set on a valid line.
                        state <= dirty_bits[req_index] ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    word_cnt <= word_cnt + 2'd1;
                    if (word_cnt == 2'd3) begin
                        state <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    word_cnt <= word_cnt + 2'd1;
                    if (word_cnt == 2'd3) begin
                        valid_bits[req_index] <= 1'b1;
                        dirty_bits[req_index] <= 1'b0;
                        state                 <= COMPARE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data storage: not reset, written by write hits and line fills.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == COMPARE && lookup_hit && req_rw) begin
                data_array[req_index][req_word] <= req_din;
            end
            if (state == ALLOCATE) begin
                data_array[req_index][word_cnt] <= mem_dout;
                if (word_cnt == 2'd3) begin
                    tag_array[req_index] <= req_tag;
                end
            end
        end
    end

    // Output decode from state; everything forced quiet while reset is held.
    always_comb begin
        is_ready        = 1'b0;
        is_output_valid = 1'b0;
        dout            = '0;
        is_hit          = 1'b0;
        mem_addr        = '0;
        mem_din         = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: is_ready = 1'b1;
                COMPARE: begin
                    if (lookup_hit) begin
                        is_output_valid = 1'b1;
                        is_hit          = !miss_flag;
                        if (!req_rw) begin
                            dout = data_array[req_index][req_word];
                        end
                    end
                end
                WRITEBACK: begin
                    mem_write = 1'b1;
                    mem_addr  = {tag_array[req_index], req_index, word_cnt, 2'b00};
                    mem_din   = data_array[req_index][word_cnt];
                end
                ALLOCATE: begin
                    mem_read = 1'b1;
                    mem_addr = {req_tag, req_index, word_cnt, 2'b00};
                end
                default: ;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // Completed-request counters, split by first-lookup outcome.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (is_output_valid) begin
            if (is_hit) begin
                hit_count <= hit_count + 32'd1;
            end else begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed self-checking bench for data_cache
module tb_data_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic        is_input_valid;
    logic [31:0] addr;
    logic        mem_rw;
    logic [31:0] din;
    logic        is_ready;
    logic        is_output_valid;
    logic [31:0] dout;
    logic        is_hit;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_dout;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:1023];
    logic        tb_we;
    logic [31:0] tb_waddr;
    logic [31:0] tb_wdata;

    logic [31:0] rd_addr [8];
    logic [31:0] wr_addr [8];
    logic [31:0] wr_data [8];
    int          rd_n;
    int          wr_n;
    int          lat;
    logic        out_mem_busy;

    data_cache #(.LINE_COUNT(16)) dut (
        .clk(clk),
        .reset(reset),
        .is_input_valid(is_input_valid),
        .addr(addr),
        .mem_rw(mem_rw),
        .din(din),
        .is_ready(is_ready),
        .is_output_valid(is_output_valid),
        .dout(dout),
        .is_hit(is_hit),
        .mem_addr(mem_addr),
        .mem_din(mem_din),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_dout(mem_dout),
        .hit_count(hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    assign mem_dout = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[11:2]] <= mem_din;
        else if (tb_we) mem[tb_waddr[11:2]] <= tb_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic collect();
        lat = 1; rd_n = 0; wr_n = 0;
        while (!is_output_valid && lat < 20) begin
            if (mem_read && rd_n < 8) begin rd_addr[rd_n] = mem_addr; rd_n++; end
            if (mem_write && wr_n < 8) begin wr_addr[wr_n] = mem_addr; wr_data[wr_n] = mem_din; wr_n++; end
            @(negedge clk);
            lat++;
        end
        out_mem_busy = mem_read | mem_write;
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!is_ready && guard < 20) begin @(negedge clk); guard++; end
    endtask

    task automatic run_req(input logic [31:0] a, input logic rw, input logic [31:0] d);
        addr = a; mem_rw = rw; din = d; is_input_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        is_input_valid = 1'b0;
        collect();
    endtask

    initial begin
        int quiet;
        reset = 1'b1; is_input_valid = 1'b0; addr = '0; mem_rw = 1'b0; din = '0;
        tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            preload(32'h10  + 4*k, 32'hA0 + k);
            preload(32'h110 + 4*k, 32'hB0 + k);
            preload(32'h200 + 4*k, 32'hC0 + k);
            preload(32'h40  + 4*k, 32'hD0 + k);
        end
        check("rst_out_valid", {31'b0, is_output_valid}, 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_is_hit", {31'b0, is_hit}, 32'd0);
        check("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'b0, is_ready}, 32'd1);
        check("idle_mem_addr", mem_addr, 32'd0);
        check("idle_mem_din", mem_din, 32'd0);

        // clean miss
        run_req(32'h14, 1'b0, 32'd0);
        check("miss_lat", lat, 32'd6);
        check("miss_dout", dout, 32'hA1);
        check("miss_hit", {31'b0, is_hit}, 32'd0);
        check("miss_rd_n", rd_n, 32'd4);
        check("miss_wr_n", wr_n, 32'd0);
        for (int k = 0; k < 4; k++) check($sformatf("miss_rd_addr%0d", k), rd_addr[k], 32'h10 + 4*k);

        // read hit
        run_req(32'h18, 1'b0, 32'd0);
        check("hit_lat", lat, 32'd1);
        check("hit_dout", dout, 32'hA2);
        check("hit_hit", {31'b0, is_hit}, 32'd1);
        check("hit_mem_busy", {31'b0, out_mem_busy}, 32'd0);

        // write hit
        run_req(32'h10, 1'b1, 32'hDEADBEEF);
        check("whit_lat", lat, 32'd1);
        check("whit_hit", {31'b0, is_hit}, 32'd1);
        check("whit_wr_n", wr_n, 32'd0);

        // dirty miss
        run_req(32'h110, 1'b0, 32'd0);
        check("dmiss_lat", lat, 32'd10);
        check("dmiss_hit", {31'b0, is_hit}, 32'd0);
        check("dmiss_dout", dout, 32'hB0);
        check("dmiss_wr_n", wr_n, 32'd4);
        check("dmiss_rd_n", rd_n, 32'd4);
        for (int k = 0; k < 4; k++) check($sformatf("dmiss_wr_addr%0d", k), wr_addr[k], 32'h10 + 4*k);
        check("dmiss_wr_data0", wr_data[0], 32'hDEADBEEF);
        check("dmiss_wr_data1", wr_data[1], 32'hA1);
        check("dmiss_rd_addr0", rd_addr[0], 32'h110);
        check("dmiss_rd_addr3", rd_addr[3], 32'h11C);
        check("mem_after_wb", mem[32'h10 >> 2], 32'hDEADBEEF);

`ifdef DCACHE_STATS_EN
        check("hit_count", hit_count, 32'd2);
        check("miss_count", miss_count, 32'd2);
`else
        check("hit_count", hit_count, 32'd0);
        check("miss_count", miss_count, 32'd0);
`endif

        // requests held during a miss are ignored until IDLE
        addr = 32'h200; mem_rw = 1'b0; is_input_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        addr = 32'h40;
        collect();
        check("hold_lat", lat, 32'd6);
        check("hold_dout", dout, 32'hC0);
        check("hold_rd_addr0", rd_addr[0], 32'h200);
        @(negedge clk);
        check("hold_ready", {31'b0, is_ready}, 32'd1);
        @(negedge clk);
        is_input_valid = 1'b0;
        collect();
        check("held_lat", lat, 32'd6);
        check("held_dout", dout, 32'hD0);
        check("held_rd_addr0", rd_addr[0], 32'h40);
        quiet = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (is_output_valid || mem_read || mem_write) quiet++;
        end
        check("held_single", quiet, 32'd0);

        // reset in the second writeback cycle
        run_req(32'h110, 1'b1, 32'h12345678);
        check("w2_hit", {31'b0, is_hit}, 32'd1);
        addr = 32'h10; mem_rw = 1'b0; is_input_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        is_input_valid = 1'b0;
        @(negedge clk);
        check("wb0_write", {31'b0, mem_write}, 32'd1);
        check("wb0_addr", mem_addr, 32'h110);
        check("wb0_din", mem_din, 32'h12345678);
        @(negedge clk);
        check("wb1_addr", mem_addr, 32'h114);
        reset = 1'b1;
        #1;
        check("rst_wb_write", {31'b0, mem_write}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("after_rst_write", {31'b0, mem_write}, 32'd0);
        check("after_rst_read", {31'b0, mem_read}, 32'd0);
        check("after_rst_ready", {31'b0, is_ready}, 32'd1);
        @(negedge clk);
        run_req(32'h10, 1'b0, 32'd0);
        check("rst_miss_hit", {31'b0, is_hit}, 32'd0);
        check("rst_miss_lat", lat, 32'd6);
        check("rst_miss_wr_n", wr_n, 32'd0);
        check("rst_miss_dout", dout, 32'hDEADBEEF);
        check("mem_wb_word0", mem[32'h110 >> 2], 32'h12345678);
        check("mem_wb_word1", mem[32'h114 >> 2], 32'hB1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter LINE_COUNT, default 16, number of direct-mapped lines; power of two, 2..256.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 is_input_valid  input  1  CPU request present this cycle.
REQ-005 addr  input  32  CPU byte address; bits [1:0] ignored.
REQ-006 mem_rw  input  1  request type: 1 write, 0 read.
REQ-007 din  input  32  CPU write data.
REQ-008 is_ready  output  1  cache accepts a request this cycle.
REQ-009 is_output_valid  output  1  one-cycle completion strobe.
REQ-010 dout  output  32  read data; valid only with is_output_valid.
REQ-011 is_hit  output  1  completed request hit on first lookup; valid only with is_output_valid.
REQ-012 mem_addr  output  32  backing-memory word-aligned byte address.
REQ-013 mem_din  output  32  backing-memory write data.
REQ-014 mem_read  output  1  backing-memory read enable; read data must return combinationally in the same cycle.
REQ-015 mem_write  output  1  backing-memory write enable; memory commits on the next rising edge.
REQ-016 mem_dout  input  32  backing-memory read data.

Function
REQ-017 Line = 4 words, 16 bytes; word offset addr[3:2]; index addr[3+log2(LINE_COUNT):4]; tag = remaining upper bits.
REQ-018 Per line: valid bit, dirty bit, tag, 4 data words; write-back, write-allocate.
REQ-019 FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE; is_ready=1 only in IDLE.
REQ-020 IDLE: is_input_valid && is_ready latches addr, mem_rw, din and clears miss flag; next state COMPARE; requests not accepted are ignored, no side effects.
REQ-021 COMPARE hit (valid && tag match): read drives dout = selected word; write updates word, sets dirty; is_output_valid=1 for that cycle; is_hit = !miss flag; next IDLE.
REQ-022 COMPARE miss: set miss flag; dirty victim -> WRITEBACK, else -> ALLOCATE; no output strobe.
REQ-023 WRITEBACK: 4 consecutive cycles, mem_write=1, mem_addr = {victim tag, index, word k, 2'b00}, k=0..3, mem_din = victim word k; then ALLOCATE.
REQ-024 ALLOCATE: 4 consecutive cycles, mem_read=1, mem_addr = {request tag, index, word k, 2'b00}, k=0..3, word k filled from mem_dout; at end line valid=1, dirty=0, tag=request tag; next COMPARE.
REQ-025 Latency from acceptance cycle: hit 1 cycle, clean miss 6 cycles, dirty miss 10 cycles; max throughput 1 request per 2 cycles.
REQ-026 mem_read and mem_write never both 1; both 0 outside WRITEBACK/ALLOCATE; mem_addr, mem_din 0 when idle.
REQ-027 Word counter 2 bits, wraps 3->0 on state exit.

Reset
REQ-028 reset forces state IDLE, clears all valid and dirty bits, word counter, miss flag, latched request.
REQ-029 During reset and the following cycle: is_ready=1 (after reset), is_output_valid=0, dout=0, is_hit=0, mem_read=0, mem_write=0.
REQ-030 Reset mid-WRITEBACK/ALLOCATE aborts the transfer; dirty data not yet written is discarded; no further memory access.
REQ-031 Tag and data arrays are not cleared by reset.

Configuration
REQ-032 Macro DCACHE_STATS_EN defined: outputs hit_count[31:0], miss_count[31:0] increment once per completed request (is_hit=1 / is_hit=0), cleared by reset, wrap at 2^32.
REQ-033 Macro undefined: hit_count, miss_count ports remain, tied to 0; no counter logic.

Verification
REQ-034 After reset, memory words 0x10..0x1C = 0xA0..0xA3; read 0x14 -> mem_read at 0x10,0x14,0x18,0x1C, is_output_valid 6 cycles after acceptance, dout=0xA1, is_hit=0.
REQ-035 Then read 0x18 -> is_output_valid next cycle, dout=0xA2, is_hit=1, mem_read/mem_write stay 0.
REQ-036 Write 0x10 din=0xDEADBEEF (hit, no memory write); read 0x110 (index 1, new tag) -> mem_write at 0x10..0x1C with first data 0xDEADBEEF, then mem_read at 0x110..0x11C, output 10 cycles after acceptance, is_hit=0.
REQ-037 Assert is_input_valid with addr 0x40 continuously during a miss -> ignored while is_ready=0; single request accepted on return to IDLE.
REQ-038 Assert reset in 2nd WRITEBACK cycle -> mem_write=0 next cycle, is_ready=1; subsequent read of 0x10 misses (is_hit=0).
REQ-039 With DCACHE_STATS_EN, after REQ-034..REQ-036 sequence -> hit_count=2, miss_count=2; without it both read 0.
